evo_scheduler: RTL and testbench

EVO_SCHEDULER -- requirements
Module: evo_scheduler

---
 rtl/evo_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_evo_scheduler.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evo_scheduler.sv
// evo_scheduler: paces generations of the evolution engine, services single
// cell edits and full-board clears, and decides who owns the board RAM.
// All outputs are registered; each transition sets the outputs for the state
// being entered so they are valid for the whole of that state.
module evo_scheduler #(
  parameter int P_PARAM_M = 5,
  parameter int P_PARAM_N = 5,
  parameter int WIDTH     = 12,
  parameter int TICK_BASE = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_sw,
  input  logic               step_btn,
  input  logic               clear_btn,
  input  logic [2:0]         period_sel,
  input  logic               edit_req,
  input  logic [2*WIDTH-1:0] edit_pos,
  input  logic               edit_val,
  input  logic               engine_copy_wden,
  output logic               evo_toggle,
  output logic               engine_owns_ram,
  output logic               ram_wden,
  output logic [2*WIDTH-1:0] ram_wr_pos,
  output logic               ram_wr_val,
  output logic               edit_ack,
  output logic [15:0]        gen_count,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam logic [PW-1:0] CELLS    = PW'(P_PARAM_M * P_PARAM_N);
  localparam logic [PW-1:0] LAST_IDX = PW'(P_PARAM_M * P_PARAM_N - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_EVOLVE = 3'd2;
  localparam logic [2:0] S_EDIT   = 3'd3;
  localparam logic [2:0] S_CLEAR  = 3'd4;

  logic [2:0]    state;
  logic [2:0]    ret_state;
  logic [31:0]   tick_cnt;
  logic [31:0]   period_m1;
  logic [PW-1:0] clr_idx;
  logic          pend_clr;
  logic          prev_wden;
  logic          tick_hit;
  logic          done_edge;

  // Period limit follows period_sel every cycle; >= lets a shortened period fire at once.
  always_comb begin
    period_m1 = (32'(TICK_BASE) << period_sel) - 32'd1;
    tick_hit  = (tick_cnt >= period_m1);
    done_edge = prev_wden & ~engine_copy_wden;
  end

  // Previous engine copy-write enable, used to find its falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_wden <= 1'b0;
    else        prev_wden <= engine_copy_wden;
  end

  // Scheduler state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      ret_state       <= S_IDLE;
      tick_cnt        <= 32'd0;
      clr_idx         <= '0;
      pend_clr        <= 1'b0;
      evo_toggle      <= 1'b0;
      engine_owns_ram <= 1'b0;
      ram_wden        <= 1'b0;
      ram_wr_pos      <= '0;
      ram_wr_val      <= 1'b0;
      edit_ack        <= 1'b0;
      gen_count       <= 16'd0;
      busy            <= 1'b0;
    end else begin
      edit_ack <= 1'b0;
      ram_wden <= 1'b0;
      case (state)
        S_IDLE, S_WAIT: begin
          if (pend_clr || clear_btn) begin
            state           <= S_CLEAR;
            clr_idx         <= '0;
            pend_clr        <= 1'b0;
            gen_count       <= 16'd0;
            tick_cnt        <= 32'd0;
            ram_wden        <= 1'b1;
            ram_wr_pos      <= '0;
            ram_wr_val      <= 1'b0;
            engine_owns_ram <= 1'b0;
            busy            <= 1'b1;
          end else if (edit_req) begin
            // Out-of-range positions are acknowledged but never written.
            state      <= S_EDIT;
            ret_state  <= state;
            edit_ack   <= 1'b1;
            ram_wden   <= (edit_pos < CELLS);
            ram_wr_pos <= edit_pos;
            ram_wr_val <= edit_val;
            busy       <= 1'b1;
          end else if (step_btn || (state == S_WAIT && run_sw && tick_hit)) begin
            state           <= S_EVOLVE;
            evo_toggle      <= ~evo_toggle;
            tick_cnt        <= 32'd0;
            engine_owns_ram <= 1'b1;
            busy            <= 1'b1;
          end else if (state == S_IDLE) begin
            if (run_sw) begin
              state    <= S_WAIT;
              tick_cnt <= 32'd0;
              busy     <= 1'b1;
            end
          end else if (!run_sw) begin
            state    <= S_IDLE;
            tick_cnt <= 32'd0;
            busy     <= 1'b0;
          end else begin
            tick_cnt <= tick_cnt + 32'd1;
          end
        end
        S_EVOLVE: begin
          if (clear_btn) pend_clr <= 1'b1;
          if (done_edge) begin
            engine_owns_ram <= 1'b0;
            if (pend_clr || clear_btn) begin
              state      <= S_CLEAR;
              clr_idx    <= '0;
              pend_clr   <= 1'b0;
              gen_count  <= 16'd0;
              tick_cnt   <= 32'd0;
              ram_wden   <= 1'b1;
              ram_wr_pos <= '0;
              ram_wr_val <= 1'b0;
            end else begin
              gen_count <= gen_count + 16'd1;
              tick_cnt  <= 32'd0;
              if (run_sw) begin
                state <= S_WAIT;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        S_EDIT: begin
          // Tick counter is left untouched so a paused WAIT resumes where it was.
          state <= ret_state;
          busy  <= (ret_state != S_IDLE);
        end
        S_CLEAR: begin
          if (clr_idx == LAST_IDX) begin
            tick_cnt <= 32'd0;
            if (run_sw) begin
              state <= S_WAIT;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clr_idx    <= clr_idx + 1'b1;
            ram_wden   <= 1'b1;
            ram_wr_pos <= clr_idx + 1'b1;
            ram_wr_val <= 1'b0;
          end
        end
        default: begin
          state           <= S_IDLE;
          engine_owns_ram <= 1'b0;
          busy            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_evo_scheduler.sv
// Testbench for evo_scheduler: directed tables and sequences for timing and
// corner cases, then random edit/step/clear traffic against a board model.
module tb_evo_scheduler;

  localparam int PW    = 24;
  localparam int CELLS = 25;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run_sw, step_btn, clear_btn, edit_req, edit_val, engine_copy_wden;
  logic [2:0]    period_sel;
  logic [PW-1:0] edit_pos;
  logic          evo_toggle, engine_owns_ram, ram_wden, ram_wr_val, edit_ack, busy;
  logic [PW-1:0] ram_wr_pos;
  logic [15:0]   gen_count;

  int n_pass  = 0;
  int n_total = 0;
  int wr_cnt  = 0;
  int oob_wr  = 0;
  logic obs [0:31];
  logic mdl [0:31];
  logic        exp_tog;
  logic [15:0] exp_gen;

  typedef struct {
    logic [PW-1:0] pos;
    logic          val;
    logic          exp_wden;
    logic          exp_ack;
  } edit_vec_t;

  typedef struct {
    logic [2:0] sel;
    int         cycles;
  } period_vec_t;

  edit_vec_t   etab [6];
  period_vec_t ptab [4];

  evo_scheduler #(
    .P_PARAM_M(5), .P_PARAM_N(5), .WIDTH(12), .TICK_BASE(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run_sw(run_sw), .step_btn(step_btn),
    .clear_btn(clear_btn), .period_sel(period_sel), .edit_req(edit_req),
    .edit_pos(edit_pos), .edit_val(edit_val), .engine_copy_wden(engine_copy_wden),
    .evo_toggle(evo_toggle), .engine_owns_ram(engine_owns_ram), .ram_wden(ram_wden),
    .ram_wr_pos(ram_wr_pos), .ram_wr_val(ram_wr_val), .edit_ack(edit_ack),
    .gen_count(gen_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Board image rebuilt from the RAM write port.
  always @(negedge clk) begin
    if (rst_n && ram_wden) begin
      wr_cnt <= wr_cnt + 1;
      if (ram_wr_pos < PW'(CELLS)) obs[ram_wr_pos[4:0]] <= ram_wr_val;
      else oob_wr <= oob_wr + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic engine_gen(input int h);
    engine_copy_wden = 1'b1;
    repeat (h) cyc();
    engine_copy_wden = 1'b0;
    cyc();
  endtask

  task automatic measure(output int n);
    logic t0;
    t0 = evo_toggle;
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      cyc();
      if (evo_toggle !== t0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_edit(input logic [PW-1:0] p, input logic v);
    bit got;
    got = 1'b0;
    edit_req = 1'b1;
    edit_pos = p;
    edit_val = v;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (edit_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("edit_ack_timeout", 0, 1);
    edit_req = 1'b0;
    cyc();
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy === 1'b0) begin
        done = 1'b1;
        break;
      end
      cyc();
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  task automatic board_chk(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < CELLS; i++) if (obs[i] !== mdl[i]) bad++;
    chk(name, bad, 0);
  endtask

  initial begin
    int n, w0, err, op;
    logic [PW-1:0] p;
    logic v;

    etab[0] = '{pos: 24'd7,    val: 1'b1, exp_wden: 1'b1, exp_ack: 1'b1};
    etab[1] = '{pos: 24'd0,    val: 1'b1, exp_wden: 1'b1, exp_ack: 1'b1};
    etab[2] = '{pos: 24'd24,   val: 1'b1, exp_wden: 1'b1, exp_ack: 1'b1};
    etab[3] = '{pos: 24'd25,   val: 1'b1, exp_wden: 1'b0, exp_ack: 1'b1};
    etab[4] = '{pos: 24'd4095, val: 1'b0, exp_wden: 1'b0, exp_ack: 1'b1};
    etab[5] = '{pos: 24'd12,   val: 1'b0, exp_wden: 1'b1, exp_ack: 1'b1};
    ptab[0] = '{sel: 3'd0, cycles: 4};
    ptab[1] = '{sel: 3'd2, cycles: 16};
    ptab[2] = '{sel: 3'd3, cycles: 32};
    ptab[3] = '{sel: 3'd1, cycles: 8};

    rst_n = 1'b0; run_sw = 1'b0; step_btn = 1'b0; clear_btn = 1'b0;
    edit_req = 1'b0; edit_val = 1'b0; edit_pos = '0; engine_copy_wden = 1'b0;
    period_sel = 3'd0;
    exp_tog = 1'b0; exp_gen = 16'd0;
    for (int i = 0; i < 32; i++) mdl[i] = 1'b0;

    // Reset state
    repeat (3) cyc();
    chk("rst_toggle", evo_toggle, 0);
    chk("rst_owns", engine_owns_ram, 0);
    chk("rst_wden", ram_wden, 0);
    chk("rst_pos", ram_wr_pos, 0);
    chk("rst_val", ram_wr_val, 0);
    chk("rst_ack", edit_ack, 0);
    chk("rst_gen", gen_count, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    cyc();

    // Free-running at 8 cycles per generation
    period_sel = 3'd1; run_sw = 1'b1;
    cyc();
    chk("wait_busy", busy, 1);
    measure(n);
    chk("tick_latency_1", n, 8);
    exp_tog = ~exp_tog;
    chk("tick_toggle_1", evo_toggle, exp_tog);
    chk("evolve_owns", engine_owns_ram, 1);
    chk("evolve_no_wr", ram_wden, 0);
    engine_gen(2);
    exp_gen++;
    chk("gen_after_done", gen_count, exp_gen);
    chk("owns_released", engine_owns_ram, 0);
    measure(n);
    chk("tick_latency_2", n, 8);
    exp_tog = ~exp_tog;
    run_sw = 1'b0;
    engine_gen(2);
    exp_gen++;
    chk("gen_two", gen_count, exp_gen);
    chk("idle_after_run", busy, 0);

    // Generation period versus period_sel
    for (int i = 0; i < 4; i++) begin
      period_sel = ptab[i].sel; run_sw = 1'b1;
      cyc();
      measure(n);
      chk($sformatf("period_sel%0d", ptab[i].sel), n, ptab[i].cycles);
      exp_tog = ~exp_tog;
      run_sw = 1'b0;
      engine_gen(1 + i % 3);
      exp_gen++;
      chk("period_gen", gen_count, exp_gen);
      chk("period_idle", busy, 0);
    end

    // Shortening the period past the elapsed count fires next cycle
    period_sel = 3'd3; run_sw = 1'b1;
    cyc();
    repeat (20) cyc();
    chk("long_period_no_fire", evo_toggle, exp_tog);
    period_sel = 3'd0;
    cyc();
    exp_tog = ~exp_tog;
    chk("short_period_fire", evo_toggle, exp_tog);
    chk("short_period_owns", engine_owns_ram, 1);
    run_sw = 1'b0;
    engine_gen(2);
    exp_gen++;

    // Single step; step and edit ignored while evolving
    step_btn = 1'b1;
    cyc();
    step_btn = 1'b0;
    exp_tog = ~exp_tog;
    chk("step_toggle", evo_toggle, exp_tog);
    chk("step_busy", busy, 1);
    step_btn = 1'b1;
    cyc();
    step_btn = 1'b0;
    chk("step_in_evolve", evo_toggle, exp_tog);
    edit_req = 1'b1; edit_pos = 24'd3; edit_val = 1'b1;
    err = 0;
    repeat (3) begin
      cyc();
      if (edit_ack !== 1'b0 || ram_wden !== 1'b0) err++;
    end
    chk("edit_in_evolve", err, 0);
    engine_gen(2);
    exp_gen++;
    chk("step_gen", gen_count, exp_gen);
    chk("step_idle", busy, 0);
    cyc();
    chk("pending_edit_ack", edit_ack, 1);
    chk("pending_edit_pos", ram_wr_pos, 3);
    edit_req = 1'b0;
    cyc();
    chk("pending_edit_ack_drop", edit_ack, 0);

    // Edit vectors from IDLE
    for (int i = 0; i < 6; i++) begin
      edit_req = 1'b1; edit_pos = etab[i].pos; edit_val = etab[i].val;
      cyc();
      chk($sformatf("edit%0d_ack", i), edit_ack, etab[i].exp_ack);
      chk($sformatf("edit%0d_wden", i), ram_wden, etab[i].exp_wden);
      if (etab[i].exp_wden) begin
        chk($sformatf("edit%0d_pos", i), ram_wr_pos, etab[i].pos);
        chk($sformatf("edit%0d_val", i), ram_wr_val, etab[i].val);
      end
      edit_req = 1'b0;
      cyc();
      chk($sformatf("edit%0d_one_cycle", i), edit_ack, 0);
      chk($sformatf("edit%0d_wden_off", i), ram_wden, 0);
      chk($sformatf("edit%0d_idle", i), busy, 0);
    end

    // Back-to-back edits complete every two cycles
    edit_req = 1'b1; edit_pos = 24'd1; edit_val = 1'b1;
    cyc();
    chk("b2b_ack_a", edit_ack, 1);
    edit_pos = 24'd2;
    cyc();
    chk("b2b_gap", edit_ack, 0);
    cyc();
    chk("b2b_ack_b", edit_ack, 1);
    chk("b2b_pos_b", ram_wr_pos, 2);
    edit_req = 1'b0;
    cyc();

    // Clear requested during EVOLVE waits for the done edge
    step_btn = 1'b1;
    cyc();
    step_btn = 1'b0;
    exp_tog = ~exp_tog;
    clear_btn = 1'b1;
    cyc();
    clear_btn = 1'b0;
    w0 = wr_cnt;
    repeat (3) cyc();
    chk("no_write_before_done", wr_cnt - w0, 0);
    engine_gen(2);
    exp_gen = 16'd0;
    chk("clear_gen_zero", gen_count, 0);
    err = 0;
    for (int i = 0; i < CELLS; i++) begin
      chk($sformatf("sweep_pos%0d", i), ram_wr_pos, i);
      if (ram_wden !== 1'b1 || ram_wr_val !== 1'b0) err++;
      cyc();
    end
    chk("sweep_wden_val", err, 0);
    chk("sweep_count", wr_cnt - w0, 25);
    chk("sweep_end_wden", ram_wden, 0);
    chk("sweep_end_idle", busy, 0);

    // Clear and edit in the same IDLE cycle: clear first
    clear_btn = 1'b1; edit_req = 1'b1; edit_pos = 24'd9; edit_val = 1'b1;
    cyc();
    clear_btn = 1'b0;
    chk("clr_first_wden", ram_wden, 1);
    chk("clr_first_noack", edit_ack, 0);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      cyc();
      if (edit_ack === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("edit_after_sweep_delay", n, 26);
    chk("edit_after_sweep_pos", ram_wr_pos, 9);
    edit_req = 1'b0;
    cyc();
    chk("edit_after_sweep_cell9", obs[9], 1);
    chk("edit_after_sweep_cell0", obs[0], 0);

    // Random edits, steps and clears against a board model
    clear_btn = 1'b1;
    cyc();
    clear_btn = 1'b0;
    wait_idle();
    for (int i = 0; i < 32; i++) mdl[i] = 1'b0;
    exp_gen = 16'd0;
    board_chk("rand_init_board");
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 9);
      if (op < 6) begin
        p = PW'($urandom_range(0, 31));
        v = 1'($urandom_range(0, 1));
        do_edit(p, v);
        if (p < PW'(CELLS)) mdl[p[4:0]] = v;
      end else if (op < 9) begin
        step_btn = 1'b1;
        cyc();
        step_btn = 1'b0;
        repeat ($urandom_range(0, 3)) cyc();
        engine_gen($urandom_range(1, 4));
        exp_tog = ~exp_tog;
        exp_gen++;
      end else begin
        clear_btn = 1'b1;
        cyc();
        clear_btn = 1'b0;
        wait_idle();
        for (int i = 0; i < 32; i++) mdl[i] = 1'b0;
        exp_gen = 16'd0;
      end
      chk($sformatf("rand%0d_gen", k), gen_count, exp_gen);
      chk($sformatf("rand%0d_toggle", k), evo_toggle, exp_tog);
      board_chk($sformatf("rand%0d_board", k));
    end
    chk("rand_no_oob_write", oob_wr, 0);

    // Reset in the middle of a clear sweep
    do_edit(24'd20, 1'b1);
    clear_btn = 1'b1;
    cyc();
    clear_btn = 1'b0;
    repeat (10) cyc();
    chk("mid_clear_pos", ram_wr_pos, 10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_wden", ram_wden, 0);
    chk("async_rst_pos", ram_wr_pos, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_toggle", evo_toggle, 0);
    chk("async_rst_owns", engine_owns_ram, 0);
    chk("async_rst_ack", edit_ack, 0);
    chk("async_rst_gen", gen_count, 0);
    w0 = wr_cnt;
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (5) cyc();
    chk("post_rst_no_writes", wr_cnt - w0, 0);
    chk("post_rst_idle", busy, 0);
    chk("post_rst_cell20_kept", obs[20], 1);
    chk("post_rst_cell5_cleared", obs[5], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
